// File: rtl/fb_pkg.sv
`timescale 1ns/1ps
// Shared framebuffer definitions for the write engine and the VGA scan-out side.
// Holds screen geometry, address/pixel widths, the pixel type and the rectangle FSM states.
// Also provides the clipping helpers used when a rectangle command is loaded.
package fb_pkg;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int FB_ADDR_BITS = 19;
  localparam int PIXEL_BITS   = 3;

  typedef logic [FB_ADDR_BITS-1:0] fb_addr_t;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } fb_rect_state_t;

  localparam fb_addr_t H_RES_ADDR = fb_addr_t'(H_RES);

  // Exclusive right edge, clipped to the screen. 11 bits so x0+w cannot wrap.
  function automatic logic [10:0] clip_x_end(input logic [9:0] x0, input logic [9:0] w);
    logic [10:0] sum;
    sum = {1'b0, x0} + {1'b0, w};
    return (sum > 11'(H_RES)) ? 11'(H_RES) : sum;
  endfunction

  // Exclusive bottom edge, clipped to the screen. 10 bits so y0+h cannot wrap.
  function automatic logic [9:0] clip_y_end(input logic [8:0] y0, input logic [8:0] h);
    logic [9:0] sum;
    sum = {1'b0, y0} + {1'b0, h};
    return (sum > 10'(V_RES)) ? 10'(V_RES) : sum;
  endfunction

endpackage

// File: rtl/fb_rect_writer.sv
`timescale 1ns/1ps
// Rectangle-fill engine: clips a command to the screen and writes one pixel per accepted cycle.
// Latency: handshake at N, LOAD at N+1, writes from N+2, done pulse one cycle after last write.
// Backpressure: fb_write_ready low holds addr/data/en stable; cmd_ready is high only when idle.
//
// Ports:
//   clock, reset                  pixel_clock domain, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_x0/y0/w/h/color are the command fields
//   fb_write_addr/data/en/ready   framebuffer write port, address = y*H_RES + x
//   busy                          high from LOAD through DONE
//   done                          one-cycle pulse when a command completes
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [9:0]              cmd_x0,
  input  logic [8:0]              cmd_y0,
  input  logic [9:0]              cmd_w,
  input  logic [8:0]              cmd_h,
  input  logic [2:0]              cmd_color,
  output logic [FB_ADDR_BITS-1:0] fb_write_addr,
  output logic [PIXEL_BITS-1:0]   fb_write_data,
  output logic                    fb_write_en,
  input  logic                    fb_write_ready,
  output logic                    busy,
  output logic                    done
);

  fb_rect_state_t state;

  logic [9:0]  x0_q;
  logic [8:0]  y0_q;
  logic [9:0]  w_q;
  logic [8:0]  h_q;
  pixel_t      color_q;
  logic [10:0] x_end_q;
  logic [9:0]  y_end_q;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  fb_addr_t    row_base_q;

  logic     empty_c;
  logic     last_col_c;
  logic     last_row_c;
  fb_addr_t row_base_load_c;

  assign empty_c = (w_q == 10'd0) || (h_q == 9'd0) ||
                   (x0_q >= 10'(H_RES)) || (y0_q >= 9'(V_RES));

  assign last_col_c = (({1'b0, x_q} + 11'd1) == x_end_q);
  assign last_row_c = (({1'b0, y_q} + 10'd1) == y_end_q);

  // The only multiply: first row offset, computed once per command.
  assign row_base_load_c = fb_addr_t'(y0_q) * H_RES_ADDR;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      fb_write_en   <= 1'b0;
      fb_write_addr <= '0;
      fb_write_data <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      x0_q          <= '0;
      y0_q          <= '0;
      w_q           <= '0;
      h_q           <= '0;
      color_q       <= '0;
      x_end_q       <= '0;
      y_end_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      row_base_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready is always 1 here, so cmd_valid alone is the handshake.
          if (cmd_valid) begin
            x0_q      <= cmd_x0;
            y0_q      <= cmd_y0;
            w_q       <= cmd_w;
            h_q       <= cmd_h;
            color_q   <= cmd_color;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end

        LOAD: begin
          x_end_q <= clip_x_end(x0_q, w_q);
          y_end_q <= clip_y_end(y0_q, h_q);
          if (empty_c) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            row_base_q    <= row_base_load_c;
            x_q           <= x0_q;
            y_q           <= y0_q;
            fb_write_addr <= row_base_load_c + fb_addr_t'(x0_q);
            fb_write_data <= color_q;
            fb_write_en   <= 1'b1;
            state         <= WRITE;
          end
        end

        WRITE: begin
          // Outputs are only updated on an accepted write, so a stall holds them.
          if (fb_write_ready) begin
            if (last_col_c) begin
              if (last_row_c) begin
                fb_write_en <= 1'b0;
                done        <= 1'b1;
                state       <= DONE;
              end else begin
                x_q           <= x0_q;
                y_q           <= y_q + 9'd1;
                row_base_q    <= row_base_q + H_RES_ADDR;
                fb_write_addr <= row_base_q + H_RES_ADDR + fb_addr_t'(x0_q);
              end
            end else begin
              x_q           <= x_q + 10'd1;
              fb_write_addr <= row_base_q + fb_addr_t'(x_q + 10'd1);
            end
          end
        end

        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
